tmds_chan_encoder: RTL and testbench
====================================

Name: tmds_chan_encoder

Overview:
- Single-channel DVI 1.0 TMDS 8b/10b encoder with running-disparity tracking.
- Sits between VGA timing control (pixel byte, DE, HSync/VSync) and the 10:1 serializer inside the TMDS control top.
- The top instantiates three copies: blue (C0=HSync, C1=VSync), green (C0=C1=0), red (C0=C1=0).
- Two-stage pipeline in the pixel clock domain.

Parameters:
- CNT_W, 5, signed width of running disparity counter; range −16..+15 covers the legal ±10 excursion.
- OUT_REG, 1, 1 = extra output register (latency 3); 0 = encoder stage drives TMDSDout directly from stage-2 flops (latency 2).

Ports:
- PixelClk  in  1  pixel clock; all flops rising-edge.
- Rst  in  1  asynchronous, active-high reset.
- VideoDE  in  1  data enable; 1 = active pixel, 0 = blanking/control.
- C0  in  1  control bit 0 (sampled only when VideoDE=0).
- C1  in  1  control bit 1 (sampled only when VideoDE=0).
- VideoDin  in  8  pixel component byte.
- TMDSDout  out  10  encoded symbol; bit 0 is transmitted first.
- DispCnt  out  CNT_W  current running disparity (signed), for verification.

Behaviour:
- Reset (async, active-high):
  - All pipeline flops cleared: DE=0, C=00, q_m=0.
  - Disparity counter = 0.
  - TMDSDout = 10'h354 (control token C=00); DispCnt = 0.
  - Release is synchronous to the next PixelClk edge. Reset mid-frame discards in-flight symbols with no partial output.
- Stage 1 (transition minimisation), registered:
  - N1D = popcount(VideoDin), 4 bits.
  - XNOR path if N1D>4, or N1D==4 and VideoDin[0]==0; otherwise XOR path.
  - q_m[0]=D[0]; q_m[i]=q_m[i-1] XOR D[i] (XOR path) or XNOR (XNOR path), i=1..7.
  - q_m[8]=1 for the XOR path, 0 for the XNOR path.
  - Register q_m[8:0], N1q=popcount(q_m[7:0]), N0q=8−N1q, VideoDE, C1:C0.
- Stage 2 (DC balance), registered, when DE_s1=1:
  - Case A, cnt==0 or N1q==N0q:
    - out[9]=~q_m[8]; out[8]=q_m[8]; out[7:0] = q_m[8] ? q_m[7:0] : ~q_m[7:0].
    - cnt += q_m[8] ? (N1q−N0q) : (N0q−N1q).
  - Case B, (cnt>0 and N1q>N0q) or (cnt<0 and N0q>N1q):
    - out = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2·q_m[8] + (N0q−N1q).
  - Case C, otherwise:
    - out = {0, q_m[8], q_m[7:0]}.
    - cnt += (N1q−N0q) − 2·(~q_m[8]).
  - All arithmetic is signed CNT_W; counts are zero-extended before subtraction.
- Stage 2, when DE_s1=0:
  - cnt ← 0.
  - out = token: {C1,C0}=00→10'h354, 01→10'h0AB, 10→10'h154, 11→10'h2AB.
- Latency: input at edge k appears on TMDSDout after edge k+2 (OUT_REG=0) or k+3 (OUT_REG=1). DispCnt is aligned with TMDSDout.
- DE transitions: the first active pixel after blanking always starts with cnt=0. There is no guard-band insertion; that belongs to the top.
- Throughput: one symbol per clock, no stalls, no handshake.
- Out-of-domain inputs: X on VideoDin while DE=0 must not propagate to TMDSDout or the counter.

Test Plan:
- Reset then DE=0, C=00 → TMDSDout=10'h354 every cycle, DispCnt=0. Cycle through C=01/10/11 → 10'h0AB/10'h154/10'h2AB at the stated latency.
- DE=1, Din=8'h00 three consecutive cycles from cnt=0 → outputs 10'h100, 10'h3FF, 10'h100; DispCnt −8, +2, −6.
- DE=1, Din=8'hFF from cnt=0 → 10'h200, DispCnt=−8. Then DE=0 one cycle → token 10'h354, DispCnt=0.
- Random 10⁵ pixels with DE bursts of 1280 active / 370 blank → matches reference-model encoder bit-exact; |DispCnt| ≤ 10 always; decoded 10-bit stream recovers VideoDin.
- Assert Rst for 1 cycle mid active line (cnt≠0) → TMDSDout=10'h354 and DispCnt=0 immediately (async). After release, first pixel 8'h00 encodes as 10'h100.
- OUT_REG=0 vs OUT_REG=1 with identical stimulus → identical symbol streams offset by exactly one cycle.

Source files
------------

// File: rtl/tmds_chan_encoder.sv
// rtl/tmds_chan_encoder.sv - single-channel DVI TMDS 8b/10b encoder with running disparity
//
// Purpose: converts one pixel component byte (or a 2-bit control code during
// blanking) into a 10-bit TMDS symbol. There are two pipeline stages: the first
// does transition minimisation and the second does DC balancing. With OUT_REG=1
// an optional third register is added in front of the outputs.
//
// Ports:
//   PixelClk  in   1      pixel clock, all flops rising-edge
//   Rst       in   1      asynchronous active-high reset
//   VideoDE   in   1      1 = active pixel, 0 = blanking/control
//   C0, C1    in   1      control bits, used only while VideoDE=0
//   VideoDin  in   8      pixel component byte
//   TMDSDout  out  10     encoded symbol, bit 0 transmitted first
//   DispCnt   out  CNT_W  running disparity (signed), aligned with TMDSDout

module tmds_chan_encoder #(
  parameter int CNT_W   = 5,
  parameter int OUT_REG = 1
) (
  input  logic                    PixelClk,
  input  logic                    Rst,
  input  logic                    VideoDE,
  input  logic                    C0,
  input  logic                    C1,
  input  logic [7:0]              VideoDin,
  output logic [9:0]              TMDSDout,
  output logic signed [CNT_W-1:0] DispCnt
);

  localparam logic signed [CNT_W-1:0] ZERO = '0;
  localparam logic signed [CNT_W-1:0] TWO  = CNT_W'(2);

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // Transition-minimised word. Bit 8 records which path was taken: 1 = XOR, 0 = XNOR.
  function automatic logic [8:0] encode_qm(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = popcount8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++)
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~use_xnor;
    return q;
  endfunction

  // Stage 1
  logic [8:0] w_qm;
  logic [3:0] w_n1q_d;
  logic       r_de_s1;
  logic [1:0] r_c_s1;
  logic [8:0] r_qm_s1;
  logic [3:0] r_n1q_s1;

  always_comb begin
    w_qm    = encode_qm(VideoDin);
    w_n1q_d = popcount8(w_qm[7:0]);
  end

  // During blanking the data path is forced to zero, so an undefined VideoDin
  // cannot reach the symbol or the counter. The control bits are zeroed during
  // active video.
  always_ff @(posedge PixelClk or posedge Rst) begin
    if (Rst) begin
      r_de_s1  <= 1'b0;
      r_c_s1   <= 2'b00;
      r_qm_s1  <= 9'd0;
      r_n1q_s1 <= 4'd0;
    end else begin
      r_de_s1  <= VideoDE;
      r_c_s1   <= VideoDE ? 2'b00 : {C1, C0};
      r_qm_s1  <= VideoDE ? w_qm : 9'd0;
      r_n1q_s1 <= VideoDE ? w_n1q_d : 4'd0;
    end
  end

  // Stage 2
  logic signed [CNT_W-1:0] w_n1q;
  logic signed [CNT_W-1:0] w_n0q;
  logic signed [CNT_W-1:0] w_bal;
  logic signed [CNT_W-1:0] w_cnt_next;
  logic [9:0]              w_sym;
  logic [9:0]              w_token;
  logic [9:0]              r_sym_s2;
  logic signed [CNT_W-1:0] r_cnt_s2;

  always_comb begin
    case (r_c_s1)
      2'b00:   w_token = 10'h354;
      2'b01:   w_token = 10'h0AB;
      2'b10:   w_token = 10'h154;
      default: w_token = 10'h2AB;
    endcase
  end

  always_comb begin
    w_n1q      = {{(CNT_W-4){1'b0}}, r_n1q_s1};
    w_n0q      = {{(CNT_W-4){1'b0}}, 4'd8 - r_n1q_s1};
    w_bal      = w_n1q - w_n0q;
    w_sym      = w_token;
    w_cnt_next = ZERO;
    if (!r_de_s1) begin
      // Blanking: send the control token and restart the disparity from zero.
      w_sym      = w_token;
      w_cnt_next = ZERO;
    end else if ((r_cnt_s2 == ZERO) || (r_n1q_s1 == 4'd4)) begin
      // Neutral: the choice of inversion is driven by q_m[8] alone.
      w_sym      = {~r_qm_s1[8], r_qm_s1[8], r_qm_s1[8] ? r_qm_s1[7:0] : ~r_qm_s1[7:0]};
      w_cnt_next = r_qm_s1[8] ? (r_cnt_s2 + w_bal) : (r_cnt_s2 - w_bal);
    end else if (((r_cnt_s2 > ZERO) && (w_n1q > w_n0q)) ||
                 ((r_cnt_s2 < ZERO) && (w_n0q > w_n1q))) begin
      // Word would push the disparity further the same way, so invert it.
      w_sym      = {1'b1, r_qm_s1[8], ~r_qm_s1[7:0]};
      w_cnt_next = r_cnt_s2 + (r_qm_s1[8] ? TWO : ZERO) - w_bal;
    end else begin
      w_sym      = {1'b0, r_qm_s1[8], r_qm_s1[7:0]};
      w_cnt_next = r_cnt_s2 + w_bal - (r_qm_s1[8] ? ZERO : TWO);
    end
  end

  always_ff @(posedge PixelClk or posedge Rst) begin
    if (Rst) begin
      r_sym_s2 <= 10'h354;
      r_cnt_s2 <= ZERO;
    end else begin
      r_sym_s2 <= w_sym;
      r_cnt_s2 <= w_cnt_next;
    end
  end

  // Optional output register; DispCnt is delayed together with the symbol.
  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [9:0]              r_sym_s3;
      logic signed [CNT_W-1:0] r_cnt_s3;
      always_ff @(posedge PixelClk or posedge Rst) begin
        if (Rst) begin
          r_sym_s3 <= 10'h354;
          r_cnt_s3 <= ZERO;
        end else begin
          r_sym_s3 <= r_sym_s2;
          r_cnt_s3 <= r_cnt_s2;
        end
      end
      assign TMDSDout = r_sym_s3;
      assign DispCnt  = r_cnt_s3;
    end else begin : g_no_out_reg
      assign TMDSDout = r_sym_s2;
      assign DispCnt  = r_cnt_s2;
    end
  endgenerate

endmodule

// File: tb/tb_tmds_chan_encoder.sv
// tb/tb_tmds_chan_encoder.sv - self-checking bench for tmds_chan_encoder (OUT_REG=1 and OUT_REG=0)

module tb_tmds_chan_encoder;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              de  = 1'b0;
  logic              c0  = 1'b0;
  logic              c1  = 1'b0;
  logic [7:0]        din = 8'h00;
  logic [9:0]        sym3;
  logic signed [4:0] cnt3;
  logic [9:0]        sym0;
  logic signed [4:0] cnt0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tmds_chan_encoder #(.CNT_W(5), .OUT_REG(1)) dut (
    .PixelClk(clk), .Rst(rst), .VideoDE(de), .C0(c0), .C1(c1),
    .VideoDin(din), .TMDSDout(sym3), .DispCnt(cnt3)
  );

  tmds_chan_encoder #(.CNT_W(5), .OUT_REG(0)) dut0 (
    .PixelClk(clk), .Rst(rst), .VideoDE(de), .C0(c0), .C1(c1),
    .VideoDin(din), .TMDSDout(sym0), .DispCnt(cnt0)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference encoder following the DVI algorithm, written with plain integers.
  function automatic void ref_enc(input bit e, input bit [1:0] c, input bit [7:0] d,
                                  inout int cnt, output bit [9:0] s);
    int       n1, n1q, n0q;
    bit       xn;
    bit [8:0] q;
    if (!e) begin
      cnt = 0;
      case (c)
        2'b00: s = 10'h354;
        2'b01: s = 10'h0AB;
        2'b10: s = 10'h154;
        default: s = 10'h2AB;
      endcase
      return;
    end
    n1 = $countones(d);
    xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xn ? !(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = !xn;
    n1q = $countones(q[7:0]);
    n0q = 8 - n1q;
    if (cnt == 0 || n1q == n0q) begin
      s = {!q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
      cnt = q[8] ? cnt + (n1q - n0q) : cnt + (n0q - n1q);
    end else if ((cnt > 0 && n1q > n0q) || (cnt < 0 && n0q > n1q)) begin
      s = {1'b1, q[8], ~q[7:0]};
      cnt = cnt + 2 * int'(q[8]) + (n0q - n1q);
    end else begin
      s = {1'b0, q[8], q[7:0]};
      cnt = cnt + (n1q - n0q) - 2 * int'(!q[8]);
    end
  endfunction

  function automatic bit [7:0] decode(input bit [9:0] s);
    bit [7:0] q, d;
    q = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : !(q[i] ^ q[i-1]);
    return d;
  endfunction

  typedef struct {
    logic       de;
    logic [1:0] c;
    logic [7:0] din;
    logic [9:0] sym;
    int         cnt;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl[NV];

  task automatic put(input int i, input logic e, input logic [1:0] c, input logic [7:0] d,
                     input logic [9:0] s, input int n);
    tbl[i].de = e; tbl[i].c = c; tbl[i].din = d; tbl[i].sym = s; tbl[i].cnt = n;
  endtask

  localparam int NR = 1600;
  bit [7:0] r_din[NR];
  bit       r_de[NR];
  bit [9:0] r_sym[NR];
  int       r_cnt[NR];

  initial begin
    int       mcnt;
    bit [9:0] prev0;
    bit [1:0] rc;

    put(0,  1'b0, 2'b00, 8'hxx, 10'h354, 0);
    put(1,  1'b0, 2'b01, 8'hxx, 10'h0AB, 0);
    put(2,  1'b0, 2'b10, 8'hxx, 10'h154, 0);
    put(3,  1'b0, 2'b11, 8'hxx, 10'h2AB, 0);
    put(4,  1'b0, 2'b00, 8'hxx, 10'h354, 0);
    put(5,  1'b1, 2'b11, 8'h00, 10'h100, -8);
    put(6,  1'b1, 2'b11, 8'h00, 10'h3FF, 2);
    put(7,  1'b1, 2'b11, 8'h00, 10'h100, -6);
    put(8,  1'b0, 2'b00, 8'hxx, 10'h354, 0);
    put(9,  1'b1, 2'b00, 8'hFF, 10'h200, -8);
    put(10, 1'b0, 2'b00, 8'hxx, 10'h354, 0);
    put(11, 1'b1, 2'b00, 8'h55, 10'h133, 0);
    put(12, 1'b1, 2'b00, 8'h10, 10'h1F0, 0);
    put(13, 1'b1, 2'b00, 8'h01, 10'h1FF, 8);
    put(14, 1'b1, 2'b00, 8'h01, 10'h300, 2);
    put(15, 1'b1, 2'b00, 8'hFF, 10'h200, -6);
    put(16, 1'b1, 2'b00, 8'hFF, 10'h0FF, 0);
    put(17, 1'b0, 2'b00, 8'hxx, 10'h354, 0);
    put(18, 1'b0, 2'b00, 8'hxx, 10'h354, 0);
    put(19, 1'b0, 2'b00, 8'hxx, 10'h354, 0);

    // Reset state
    tick();
    tick();
    chk("reset_sym_r1", int'(sym3), 'h354);
    chk("reset_cnt_r1", int'(cnt3), 0);
    chk("reset_sym_r0", int'(sym0), 'h354);
    chk("reset_cnt_r0", int'(cnt0), 0);
    rst = 1'b0;

    // Directed table: OUT_REG=1 shows row i-2 and OUT_REG=0 shows row i-1 after edge i
    for (int i = 0; i < NV; i++) begin
      de = tbl[i].de; c0 = tbl[i].c[0]; c1 = tbl[i].c[1]; din = tbl[i].din;
      tick();
      if (i >= 2) begin
        chk($sformatf("tbl%0d_sym_r1", i-2), int'(sym3), int'(tbl[i-2].sym));
        chk($sformatf("tbl%0d_cnt_r1", i-2), int'(cnt3), tbl[i-2].cnt);
      end
      if (i >= 1) begin
        chk($sformatf("tbl%0d_sym_r0", i-1), int'(sym0), int'(tbl[i-1].sym));
        chk($sformatf("tbl%0d_cnt_r0", i-1), int'(cnt0), tbl[i-1].cnt);
      end
    end

    // Asynchronous reset in the middle of an active line
    de = 1'b1; din = 8'h00; c0 = 1'b0; c1 = 1'b0;
    tick(); tick(); tick();
    chk("midline_pre_cnt_r1", int'(cnt3), -8);
    chk("midline_pre_cnt_r0", int'(cnt0), 2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_sym_r1", int'(sym3), 'h354);
    chk("async_rst_cnt_r1", int'(cnt3), 0);
    chk("async_rst_sym_r0", int'(sym0), 'h354);
    chk("async_rst_cnt_r0", int'(cnt0), 0);
    tick();
    rst = 1'b0;
    de = 1'b1; din = 8'h00;
    tick();
    de = 1'b0; din = 8'hxx;
    tick();
    chk("post_rst_sym_r0", int'(sym0), 'h100);
    chk("post_rst_cnt_r0", int'(cnt0), -8);
    chk("post_rst_prev_r1", int'(sym3), 'h354);
    tick();
    chk("post_rst_sym_r1", int'(sym3), 'h100);
    chk("post_rst_cnt_r1", int'(cnt3), -8);
    chk("post_rst_tok_r0", int'(sym0), 'h354);
    tick(); tick();

    // Random bursts (20 blank, 60 active) against the reference model
    mcnt = 0;
    for (int i = 0; i < NR; i++) begin
      r_de[i]  = (i % 80) >= 20;
      r_din[i] = 8'($urandom);
      rc       = 2'($urandom);
      ref_enc(r_de[i], rc, r_din[i], mcnt, r_sym[i]);
      r_cnt[i] = mcnt;
      de = r_de[i]; c0 = rc[0]; c1 = rc[1];
      din = r_de[i] ? r_din[i] : 8'hxx;
      prev0 = sym0;
      tick();
      if (i >= 2) begin
        chk("rnd_sym_r1", int'(sym3), int'(r_sym[i-2]));
        chk("rnd_cnt_r1", int'(cnt3), r_cnt[i-2]);
        chk("rnd_offset", int'(sym3), int'(prev0));
        if (cnt3 > 5'sd10 || cnt3 < -5'sd10) chk("rnd_cnt_bound", int'(cnt3), 10);
        if (r_de[i-2]) chk("rnd_decode", int'(decode(sym3)), int'(r_din[i-2]));
      end
      if (i >= 1) begin
        chk("rnd_sym_r0", int'(sym0), int'(r_sym[i-1]));
        chk("rnd_cnt_r0", int'(cnt0), r_cnt[i-1]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
